// File: rtl/gf8_pkg.sv
// Shared GF(2^3) constants and the evaluator state encoding.
// Field is built over P(x) = x^3 + x^2 + 1.
package gf8_pkg;

  localparam int GF_W = 3;
  localparam logic [GF_W:0] GF_POLY = 4'b1101;
  localparam logic [GF_W-1:0] GF_ONE = 3'd1;
  localparam logic [GF_W-1:0] GF_ZERO = 3'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } gf8_state_t;

endpackage

// File: rtl/mastrovito_multiplier.sv
// Combinational GF(2^3) multiplier: Z = A * B mod GF_POLY.
// Folds B MSB-first, reducing after every shift so no width growth escapes.
module mastrovito_multiplier
  import gf8_pkg::*;
(
  input  logic [GF_W-1:0] A,
  input  logic [GF_W-1:0] B,
  output logic [GF_W-1:0] Z
);

  logic [GF_W:0] w_partial;

  always_comb begin
    w_partial = '0;
    for (int i = GF_W - 1; i >= 0; i--) begin
      w_partial = {w_partial[GF_W-1:0], 1'b0};
      if (w_partial[GF_W]) w_partial = w_partial ^ GF_POLY;
      if (B[i]) w_partial = w_partial ^ {1'b0, A};
    end
    Z = w_partial[GF_W-1:0];
  end

endmodule

// File: rtl/gf8_horner_evaluator.sv
// Streaming Horner evaluator over GF(2^3): acc = acc*point ^ coef, highest degree first.
// Outputs are registered or decoded from state, so there is no input-to-output path.
module gf8_horner_evaluator
  import gf8_pkg::*;
#(
  parameter int MAX_TERMS = 7,
  parameter int CNT_W     = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [GF_W-1:0] point,
  input  logic            coef_valid,
  output logic            coef_ready,
  input  logic [GF_W-1:0] coef_data,
  input  logic            coef_last,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [GF_W-1:0] result_data,
  output logic            result_err,
  output logic            busy
);

  gf8_state_t      r_state;
  logic [GF_W-1:0] r_acc;
  logic [GF_W-1:0] r_point;
  logic [CNT_W-1:0] r_cnt;
  logic            r_err;

  logic [GF_W-1:0] w_product;
  logic            w_beat;
  logic            w_cnt_full;

  mastrovito_multiplier u_mult (
    .A (r_acc),
    .B (r_point),
    .Z (w_product)
  );

  assign w_beat     = coef_valid && (r_state == ACCUM);
  assign w_cnt_full = (r_cnt == CNT_W'(MAX_TERMS - 1));

  assign coef_ready   = (r_state == ACCUM);
  assign result_valid = (r_state == DONE);
  assign busy         = (r_state != IDLE);
  assign result_data  = r_acc;
  assign result_err   = r_err;

  // The accumulator doubles as the result register; it only moves on a beat,
  // so it is frozen for the whole time the result is presented in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= GF_ZERO;
      r_point <= GF_ZERO;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_point <= point;
            r_acc   <= GF_ZERO;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_state <= ACCUM;
          end
        end
        ACCUM: begin
          if (w_beat) begin
            r_acc <= w_product ^ coef_data;
            r_cnt <= r_cnt + CNT_W'(1);
            if (coef_last) begin
              r_state <= DONE;
            end else if (w_cnt_full) begin
              r_err   <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          if (result_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf8_horner_evaluator.sv
// Self-checking bench for gf8_horner_evaluator.
// Reference evaluates sum(coef_i * x^k) using alpha log/antilog tables.
module tb_gf8_horner_evaluator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] point;
  logic       coef_valid;
  logic       coef_ready;
  logic [2:0] coef_data;
  logic       coef_last;
  logic       result_valid;
  logic       result_ready;
  logic [2:0] result_data;
  logic       result_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [2:0] coefs [7];

  localparam logic [2:0] ALPHA_POW [7] = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd7, 3'd3, 3'd6};

  gf8_horner_evaluator #(.MAX_TERMS(7), .CNT_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .point        (point),
    .coef_valid   (coef_valid),
    .coef_ready   (coef_ready),
    .coef_data    (coef_data),
    .coef_last    (coef_last),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_data  (result_data),
    .result_err   (result_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic int gfLog(input logic [2:0] a);
    for (int k = 0; k < 7; k++) if (ALPHA_POW[k] == a) return k;
    return 0;
  endfunction

  function automatic logic [2:0] gfMul(input logic [2:0] a, input logic [2:0] b);
    if (a == 3'd0 || b == 3'd0) return 3'd0;
    return ALPHA_POW[(gfLog(a) + gfLog(b)) % 7];
  endfunction

  // Direct sum-of-terms form, deliberately not Horner.
  function automatic logic [2:0] refEval(input logic [2:0] pt, input int n);
    logic [2:0] sum;
    logic [2:0] pw;
    sum = 3'd0;
    for (int i = 0; i < n; i++) begin
      pw = 3'd1;
      for (int j = 0; j < n - 1 - i; j++) pw = gfMul(pw, pt);
      sum = sum ^ gfMul(coefs[i], pw);
    end
    return sum;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one evaluation up to the cycle after the final beat and reports what is seen there.
  task automatic driveEval(input logic [2:0] pt, input int n, input bit useLast, input int gapPct,
                           output bit validAtOnce, output logic [2:0] data, output logic err);
    start = 1'b1;
    point = pt;
    tick;
    start = 1'b0;
    point = 3'($urandom);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < 6 && gapPct > 0 && $urandom_range(99) < gapPct; g++) begin
        coef_valid = 1'b0;
        coef_data  = 3'($urandom);
        coef_last  = 1'($urandom);
        tick;
      end
      coef_valid = 1'b1;
      coef_data  = coefs[i];
      coef_last  = useLast && (i == n - 1);
      tick;
    end
    coef_valid  = 1'b0;
    coef_last   = 1'b0;
    validAtOnce = result_valid;
    data        = result_data;
    err         = result_err;
  endtask

  task automatic releaseResult;
    result_ready = 1'b1;
    tick;
    result_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++;
    if ({result_valid, coef_ready, busy, result_err, result_data} !== 7'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b, want 0000000",
               {result_valid, coef_ready, busy, result_err, result_data});
    end
    rst = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle_busy: got %b, want 0", busy);
    end
  endtask

  task automatic test_directed;
    logic [2:0] pts  [4];
    logic [2:0] exps [4];
    int         lens [4];
    logic [2:0] vals [4][3];
    bit         v;
    logic [2:0] d;
    logic       e;
    pts  = '{3'd2, 3'd3, 3'd1, 3'd0};
    exps = '{3'd5, 3'd4, 3'd0, 3'd2};
    lens = '{3, 2, 3, 2};
    vals = '{'{3'd1, 3'd0, 3'd1}, '{3'd7, 3'd0, 3'd0}, '{3'd3, 3'd5, 3'd6}, '{3'd6, 3'd2, 3'd0}};
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 3; i++) coefs[i] = vals[t][i];
      driveEval(pts[t], lens[t], 1'b1, 0, v, d, e);
      checks++;
      if (v !== 1'b1 || d !== exps[t] || e !== 1'b0) begin
        errors++;
        $display("[TB] FAIL directed_%0d: valid=%b data=%0d err=%b, want valid=1 data=%0d err=0",
                 t, v, d, e, exps[t]);
      end
      releaseResult;
      checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL directed_release_%0d: valid=%b busy=%b, want 0 0", t, result_valid, busy);
      end
    end
  endtask

  task automatic test_backpressure;
    bit         v;
    logic [2:0] d;
    logic       e;
    logic [2:0] want;
    for (int i = 0; i < 4; i++) coefs[i] = 3'($urandom);
    want = refEval(3'd6, 4);
    driveEval(3'd6, 4, 1'b1, 40, v, d, e);
    checks++;
    if (v !== 1'b1 || d !== want || e !== 1'b0) begin
      errors++;
      $display("[TB] FAIL backpressure_result: valid=%b data=%0d err=%b, want 1 %0d 0", v, d, e, want);
    end
    for (int c = 0; c < 5; c++) begin
      coef_valid = 1'($urandom);
      coef_data  = 3'($urandom);
      coef_last  = 1'($urandom);
      start      = 1'($urandom);
      tick;
      checks++;
      if (result_valid !== 1'b1 || coef_ready !== 1'b0 || result_data !== want || result_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL backpressure_hold_%0d: valid=%b ready=%b data=%0d err=%b, want 1 0 %0d 0",
                 c, result_valid, coef_ready, result_data, result_err, want);
      end
    end
    coef_valid = 1'b0;
    coef_last  = 1'b0;
    start      = 1'b0;
    releaseResult;
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL backpressure_release: valid=%b busy=%b, want 0 0", result_valid, busy);
    end
  endtask

  task automatic test_overflow;
    bit         v;
    logic [2:0] d;
    logic       e;
    logic [2:0] want;
    for (int i = 0; i < 7; i++) coefs[i] = 3'd1;
    driveEval(3'd2, 7, 1'b0, 0, v, d, e);
    checks++;
    if (v !== 1'b1 || d !== 3'd0 || e !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_err: valid=%b data=%0d err=%b, want 1 0 1", v, d, e);
    end
    releaseResult;
    for (int i = 0; i < 7; i++) coefs[i] = 3'($urandom);
    want = refEval(3'd5, 7);
    driveEval(3'd5, 7, 1'b1, 20, v, d, e);
    checks++;
    if (v !== 1'b1 || d !== want || e !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_length_last: valid=%b data=%0d err=%b, want 1 %0d 0", v, d, e, want);
    end
    releaseResult;
  endtask

  task automatic test_midreset;
    bit         v;
    logic [2:0] d;
    logic       e;
    logic [2:0] want;
    start = 1'b1;
    point = 3'd3;
    tick;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      coef_valid = 1'b1;
      coef_data  = 3'd5 + 3'(i);
      coef_last  = 1'b0;
      tick;
    end
    coef_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if ({result_valid, coef_ready, busy, result_err, result_data} !== 7'd0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got %b, want 0000000",
               {result_valid, coef_ready, busy, result_err, result_data});
    end
    for (int i = 0; i < 3; i++) coefs[i] = 3'($urandom);
    want = refEval(3'd7, 3);
    driveEval(3'd7, 3, 1'b1, 0, v, d, e);
    checks++;
    if (v !== 1'b1 || d !== want || e !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_fresh: valid=%b data=%0d err=%b, want 1 %0d 0", v, d, e, want);
    end
    releaseResult;
  endtask

  task automatic test_back_to_back;
    bit         v;
    logic [2:0] d;
    logic       e;
    logic [2:0] want;
    for (int i = 0; i < 2; i++) coefs[i] = 3'($urandom);
    driveEval(3'd4, 2, 1'b1, 0, v, d, e);
    result_ready = 1'b1;
    start        = 1'b1;
    tick;
    result_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_start_dropped: busy=%b valid=%b, want 0 0", busy, result_valid);
    end
    for (int i = 0; i < 5; i++) coefs[i] = 3'($urandom);
    want = refEval(3'd3, 5);
    driveEval(3'd3, 5, 1'b1, 0, v, d, e);
    checks++;
    if (v !== 1'b1 || d !== want || e !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_second: valid=%b data=%0d err=%b, want 1 %0d 0", v, d, e, want);
    end
    releaseResult;
  endtask

  task automatic test_random;
    bit         v;
    logic [2:0] d;
    logic       e;
    logic [2:0] want;
    logic [2:0] pt;
    bit         useLast;
    int         n;
    for (int t = 0; t < 25; t++) begin
      useLast = ($urandom_range(4) != 0);
      n       = useLast ? int'($urandom_range(1, 7)) : 7;
      pt      = 3'($urandom);
      for (int i = 0; i < n; i++) coefs[i] = 3'($urandom);
      want = refEval(pt, n);
      driveEval(pt, n, useLast, 30, v, d, e);
      checks++;
      if (v !== 1'b1 || d !== want || e !== !useLast) begin
        errors++;
        $display("[TB] FAIL random_%0d: valid=%b data=%0d err=%b, want 1 %0d %b", t, v, d, e, want, !useLast);
      end
      for (int w = $urandom_range(3); w > 0; w--) tick;
      releaseResult;
    end
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    point        = 3'd0;
    coef_valid   = 1'b0;
    coef_data    = 3'd0;
    coef_last    = 1'b0;
    result_ready = 1'b0;
    for (int i = 0; i < 7; i++) coefs[i] = 3'd0;
    test_reset;
    test_directed;
    test_backpressure;
    test_overflow;
    test_midreset;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
